bm1387_job_dispatcher: RTL and testbench

BM1387_JOB_DISPATCHER -- requirements
Module: bm1387_job_dispatcher

---
 rtl/bm1387_pkg.sv | 10 +
 rtl/bm1387_result_fifo.sv | 38 +++
 rtl/bm1387_job_dispatcher.sv | 121 ++++++++++++
 tb/tb_bm1387_job_dispatcher.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bm1387_pkg.sv
// bm1387_pkg: shared FSM states, ASIC status codes and control bit indices for the BM1387 dispatcher.
package bm1387_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ACK, S_STOP} state_e;
  localparam logic [7:0] STAT_IDLE       = 8'h00;
  localparam logic [7:0] STAT_INIT       = 8'h01;
  localparam logic [7:0] STAT_FOUND      = 8'h02;
  localparam logic [7:0] STAT_RANGE_DONE = 8'h03;
  localparam int CTRL_RUN = 0;
  localparam int CTRL_ACK = 1;
endpackage

// File: rtl/bm1387_result_fifo.sv
// bm1387_result_fifo: first-word fall-through nonce FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module bm1387_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] din,
  output logic        can_push,
  output logic        valid,
  input  logic        ready,
  output logic [31:0] dout
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          pop, wr_en;
  assign valid    = cnt_q != '0;
  assign pop      = valid & ready;
  assign can_push = (cnt_q != (AW+1)'(DEPTH)) | pop;
  assign wr_en    = push & can_push;
  assign dout     = valid ? mem_q[rd_q] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/bm1387_job_dispatcher.sv
// bm1387_job_dispatcher: hands host jobs to a BM1387 ASIC, collects found nonces into a result FIFO,
// and tracks watchdog timeouts, completed jobs and thermal-throttle time.
module bm1387_job_dispatcher
  import bm1387_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic         clk_100m,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_hdr_in,
  input  logic [31:0]  job_nonce_in,
  input  logic [31:0]  job_range_in,
  output logic [255:0] job_header,
  output logic [31:0]  start_nonce,
  output logic [31:0]  nonce_range,
  output logic         mining_enable,
  output logic [7:0]   control_reg,
  input  logic [31:0]  found_nonce,
  input  logic         hash_valid,
  input  logic         pipeline_busy,
  input  logic [7:0]   status_reg,
  input  logic         thermal_throttle,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output logic         busy,
  output logic         timeout_err,
  output logic [15:0]  jobs_done,
  output logic [31:0]  throttle_cycles
);
  state_e         state_q, state_d;
  logic [255:0]   hdr_q, hdr_d;
  logic [31:0]    nonce_q, nonce_d, range_q, range_d, wd_q, wd_d, thr_q, thr_d;
  logic [15:0]    jd_q, jd_d;
  logic           err_q, err_d, push, can_push, unused_ok;
  assign unused_ok = pipeline_busy;
  bm1387_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_100m), .rst(reset), .push(push), .din(found_nonce), .can_push(can_push),
    .valid(res_valid), .ready(res_ready), .dout(res_nonce)
  );
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    nonce_d = nonce_q;
    range_d = range_q;
    wd_d    = wd_q;
    thr_d   = thr_q;
    err_d   = err_q;
    jd_d    = jd_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: if (job_valid) begin
        hdr_d   = job_hdr_in;
        nonce_d = job_nonce_in;
        range_d = job_range_in;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: if (thermal_throttle) thr_d = thr_q + 32'(thr_q != '1);
      else begin
        wd_d = wd_q + 32'd1;
        // a result stalled behind a full FIFO still ages the watchdog
        if (hash_valid && can_push) begin
          push    = 1'b1;
          state_d = S_ACK;
        end else if (!hash_valid && status_reg == STAT_RANGE_DONE) state_d = S_STOP;
        else if (wd_q == TIMEOUT_CYCLES - 32'd1) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end
      end
      S_ACK: if (!hash_valid) state_d = S_STOP;
      S_STOP: begin
        jd_d    = jd_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_100m or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      nonce_q <= '0;
      range_q <= '0;
      wd_q    <= '0;
      thr_q   <= '0;
      err_q   <= 1'b0;
      jd_q    <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      nonce_q <= nonce_d;
      range_q <= range_d;
      wd_q    <= wd_d;
      thr_q   <= thr_d;
      err_q   <= err_d;
      jd_q    <= jd_d;
    end
  end
  always_comb begin
    control_reg           = '0;
    control_reg[CTRL_RUN] = mining_enable;
    control_reg[CTRL_ACK] = state_q == S_ACK;
  end
  assign mining_enable   = state_q inside {S_LOAD, S_RUN, S_ACK};
  assign busy            = state_q != S_IDLE;
  assign job_ready       = state_q == S_IDLE && !reset;
  assign job_header      = hdr_q;
  assign start_nonce     = nonce_q;
  assign nonce_range     = range_q;
  assign timeout_err     = err_q;
  assign jobs_done       = jd_q;
  assign throttle_cycles = thr_q;
endmodule

// File: tb/tb_bm1387_job_dispatcher.sv
// tb_bm1387_job_dispatcher: table-driven job/result sequences plus hand-written FIFO-full, watchdog, throttle and reset corners.
module tb_bm1387_job_dispatcher;
  logic         clk_100m = 1'b0, reset = 1'b1;
  logic         job_valid = 0, hash_valid = 0, pipeline_busy = 0, thermal_throttle = 0, res_ready = 0;
  logic [255:0] job_hdr_in = 256'h1;
  logic [31:0]  job_nonce_in = 32'h100, job_range_in = 32'h10, found_nonce = 0;
  logic [7:0]   status_reg = 0;
  logic         job_ready, mining_enable, res_valid, busy, timeout_err;
  logic [255:0] job_header;
  logic [31:0]  start_nonce, nonce_range, res_nonce, throttle_cycles;
  logic [7:0]   control_reg;
  logic [15:0]  jobs_done;
  int tests = 0, fails = 0;

  bm1387_job_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(32'd20)) dut (
    .clk_100m(clk_100m), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_hdr_in(job_hdr_in), .job_nonce_in(job_nonce_in), .job_range_in(job_range_in),
    .job_header(job_header), .start_nonce(start_nonce), .nonce_range(nonce_range),
    .mining_enable(mining_enable), .control_reg(control_reg), .found_nonce(found_nonce),
    .hash_valid(hash_valid), .pipeline_busy(pipeline_busy), .status_reg(status_reg),
    .thermal_throttle(thermal_throttle), .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .busy(busy), .timeout_err(timeout_err), .jobs_done(jobs_done),
    .throttle_cycles(throttle_cycles)
  );

  always #5 clk_100m = ~clk_100m;

  typedef struct packed {
    logic jv, hv, rr;
    logic [7:0] st;
    logic [31:0] fn;
    logic [59:0] exp;
  } vec_t;
  vec_t vt [17];

  function automatic vec_t mk(input logic jv, hv, rr, input logic [7:0] st, input logic [31:0] fn,
                              input logic jr, me, input logic [7:0] ctrl, input logic bz, rv,
                              input logic [31:0] rn, input logic [15:0] jd);
    return '{jv: jv, hv: hv, rr: rr, st: st, fn: fn, exp: {jr, me, ctrl, bz, rv, rn, jd}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //           jv hv rr st     fn        jr me ctrl   bz rv rn        jd
    vt[0]  = mk(1, 0, 0, 8'h00, 32'h0,    0, 1, 8'h01, 1, 0, 32'h0,    16'd0);
    vt[1]  = mk(0, 0, 0, 8'h00, 32'h0,    0, 1, 8'h01, 1, 0, 32'h0,    16'd0);
    vt[2]  = mk(0, 1, 0, 8'h00, 32'h105,  0, 1, 8'h03, 1, 1, 32'h105,  16'd0);
    vt[3]  = mk(0, 1, 0, 8'h00, 32'h105,  0, 1, 8'h03, 1, 1, 32'h105,  16'd0);
    vt[4]  = mk(0, 0, 0, 8'h00, 32'h0,    0, 0, 8'h00, 1, 1, 32'h105,  16'd0);
    vt[5]  = mk(0, 0, 0, 8'h00, 32'h0,    1, 0, 8'h00, 0, 1, 32'h105,  16'd1);
    vt[6]  = mk(0, 0, 1, 8'h00, 32'h0,    1, 0, 8'h00, 0, 0, 32'h0,    16'd1);
    vt[7]  = mk(1, 0, 0, 8'h00, 32'h0,    0, 1, 8'h01, 1, 0, 32'h0,    16'd1);
    vt[8]  = mk(0, 0, 0, 8'h00, 32'h0,    0, 1, 8'h01, 1, 0, 32'h0,    16'd1);
    vt[9]  = mk(0, 0, 0, 8'h03, 32'h0,    0, 0, 8'h00, 1, 0, 32'h0,    16'd1);
    vt[10] = mk(0, 0, 0, 8'h00, 32'h0,    1, 0, 8'h00, 0, 0, 32'h0,    16'd2);
    vt[11] = mk(1, 0, 0, 8'h00, 32'h0,    0, 1, 8'h01, 1, 0, 32'h0,    16'd2);
    vt[12] = mk(0, 0, 0, 8'h00, 32'h0,    0, 1, 8'h01, 1, 0, 32'h0,    16'd2);
    vt[13] = mk(0, 1, 0, 8'h03, 32'hABCD, 0, 1, 8'h03, 1, 1, 32'hABCD, 16'd2);
    vt[14] = mk(1, 0, 0, 8'h00, 32'h0,    0, 0, 8'h00, 1, 1, 32'hABCD, 16'd2);
    vt[15] = mk(1, 0, 0, 8'h00, 32'h0,    1, 0, 8'h00, 0, 1, 32'hABCD, 16'd3);
    vt[16] = mk(0, 0, 1, 8'h00, 32'h0,    1, 0, 8'h00, 0, 0, 32'h0,    16'd3);

    #2;
    chk("rst_outputs", {job_ready, mining_enable, control_reg, busy, res_valid, res_nonce, jobs_done}, 64'h0);
    chk("rst_status", {timeout_err, throttle_cycles, start_nonce[15:0], nonce_range[15:0]}, 64'h0);
    chk("rst_hdr", job_header[63:0], 64'h0);
    @(negedge clk_100m);
    @(negedge clk_100m);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {job_ready, busy}, 64'h2);

    for (int i = 0; i < 17; i++) begin
      job_valid = vt[i].jv; hash_valid = vt[i].hv; res_ready = vt[i].rr;
      status_reg = vt[i].st; found_nonce = vt[i].fn;
      @(negedge clk_100m);
      chk($sformatf("vec%0d", i), {job_ready, mining_enable, control_reg, busy, res_valid, res_nonce, jobs_done}, 64'(vt[i].exp));
      if (i == 0) begin
        chk("job_header", job_header[63:0], 64'h1);
        chk("start_nonce", start_nonce, 64'h100);
        chk("nonce_range", nonce_range, 64'h10);
      end
    end
    job_valid = 0; hash_valid = 0; res_ready = 0; status_reg = 0;

    // fill the FIFO with four results, fifth job must stall in RUN
    for (int k = 0; k < 4; k++) do_job(32'h11 + 32'(k));
    chk("full_head", {res_valid, res_nonce, jobs_done}, {1'b1, 32'h11, 16'd7});
    job_valid = 1;
    @(negedge clk_100m); job_valid = 0;
    @(negedge clk_100m); hash_valid = 1; found_nonce = 32'h15;
    @(negedge clk_100m);
    chk("stall_ctrl1", {mining_enable, control_reg, busy}, {1'b1, 8'h01, 1'b1});
    @(negedge clk_100m);
    chk("stall_ctrl2", {control_reg, res_nonce}, {8'h01, 32'h11});
    res_ready = 1;
    @(negedge clk_100m);
    res_ready = 0;
    chk("push_on_pop_ack", {control_reg, res_valid, res_nonce}, {8'h03, 1'b1, 32'h12});
    hash_valid = 0;
    @(negedge clk_100m);
    @(negedge clk_100m);
    chk("fifth_done", {job_ready, jobs_done}, {1'b1, 16'd8});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), {res_valid, res_nonce}, {1'b1, 32'h12 + 32'(k)});
      res_ready = 1;
      @(negedge clk_100m);
    end
    res_ready = 0;
    chk("drained", res_valid, 64'h0);

    // watchdog: silent ASIC for 20 RUN cycles
    job_valid = 1;
    @(negedge clk_100m); job_valid = 0;
    repeat (20) @(negedge clk_100m);
    chk("wd_before", {mining_enable, timeout_err}, 64'h2);
    @(negedge clk_100m);
    chk("wd_stop", {mining_enable, control_reg, busy, timeout_err}, {1'b0, 8'h00, 1'b1, 1'b1});
    @(negedge clk_100m);
    chk("wd_idle", {job_ready, timeout_err, jobs_done}, {1'b1, 1'b1, 16'd9});

    reset = 1;
    @(negedge clk_100m); @(negedge clk_100m);
    reset = 0;
    #1;
    chk("err_cleared", {timeout_err, jobs_done}, 64'h0);

    // throttle for 50 RUN cycles must not trip the 20-cycle watchdog
    thermal_throttle = 1; job_valid = 1;
    @(negedge clk_100m); job_valid = 0;
    repeat (51) @(negedge clk_100m);
    thermal_throttle = 0; status_reg = 8'h03;
    chk("thr_count", {busy, mining_enable, timeout_err, throttle_cycles}, {1'b1, 1'b1, 1'b0, 32'd50});
    @(negedge clk_100m);
    chk("thr_stop", {mining_enable, control_reg, timeout_err}, 64'h0);
    status_reg = 0;
    @(negedge clk_100m);
    chk("thr_idle", {job_ready, jobs_done, throttle_cycles}, {1'b1, 16'd1, 32'd50});

    // asynchronous reset in ACK
    job_valid = 1;
    @(negedge clk_100m); job_valid = 0;
    @(negedge clk_100m); hash_valid = 1; found_nonce = 32'h77;
    @(negedge clk_100m);
    chk("ack_before_rst", {control_reg, res_valid}, {8'h03, 1'b1});
    #1 reset = 1;
    #1;
    chk("rst_in_ack", {job_ready, mining_enable, control_reg, busy, res_valid, res_nonce, jobs_done}, 64'h0);
    chk("rst_in_ack_regs", {throttle_cycles, start_nonce}, 64'h0);
    @(negedge clk_100m);
    reset = 0; hash_valid = 0;
    #1;
    chk("idle_after_rst", {job_ready, busy, res_valid, mining_enable}, 64'h8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic do_job(input logic [31:0] f);
    job_valid = 1;
    @(negedge clk_100m); job_valid = 0;
    @(negedge clk_100m); hash_valid = 1; found_nonce = f;
    @(negedge clk_100m); hash_valid = 0;
    @(negedge clk_100m);
    @(negedge clk_100m);
  endtask
endmodule
